// File: rtl/uart_pkg.sv
// uart_pkg: frame phase encoding and default data width shared by the UART blocks.
package uart_pkg;
    localparam int UART_MAX_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } phase_e;
endpackage

// File: rtl/uart_frame_counter.sv
// uart_frame_counter: steps through start, data, parity and stop fields on baud ticks.
module uart_frame_counter
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS = UART_MAX_DATA_BITS,
    localparam int CNT_W = $clog2(MAX_DATA_BITS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             tick_en,
    input  logic [CNT_W-1:0] cfg_data_bits,
    input  logic             cfg_parity_en,
    input  logic             cfg_stop2,
    output logic             busy,
    output phase_e           phase,
    output logic [CNT_W-1:0] bit_index,
    output logic             bit_done,
    output logic             data_done,
    output logic             frame_done
);
    localparam logic [CNT_W-1:0] MAX_DB = CNT_W'(MAX_DATA_BITS);

    phase_e           phase_n;
    logic [CNT_W-1:0] bit_index_n, data_bits, data_bits_n, cfg_clamped;
    logic             stop_cnt, stop_cnt_n, parity_en, parity_en_n, stop2, stop2_n;
    logic             busy_n, bit_done_n, data_done_n, frame_done_n;

    assign cfg_clamped = (cfg_data_bits == '0 || cfg_data_bits > MAX_DB) ? MAX_DB : cfg_data_bits;

    always_comb begin
        phase_n      = phase;
        bit_index_n  = bit_index;
        stop_cnt_n   = stop_cnt;
        data_bits_n  = data_bits;
        parity_en_n  = parity_en;
        stop2_n      = stop2;
        bit_done_n   = 1'b0;
        data_done_n  = 1'b0;
        frame_done_n = 1'b0;
        case (phase)
            IDLE: if (start) begin
                phase_n     = START;
                bit_index_n = '0;
                stop_cnt_n  = 1'b0;
                data_bits_n = cfg_clamped;
                parity_en_n = cfg_parity_en;
                stop2_n     = cfg_stop2;
            end
            START: if (tick_en) begin
                phase_n    = DATA;
                bit_done_n = 1'b1;
            end
            DATA: if (tick_en) begin
                bit_done_n  = 1'b1;
                data_done_n = 1'b1;
                phase_n     = (bit_index == data_bits - CNT_W'(1)) ? (parity_en ? PARITY : STOP) : DATA;
                bit_index_n = (bit_index == data_bits - CNT_W'(1)) ? '0 : bit_index + CNT_W'(1);
            end
            PARITY: if (tick_en) begin
                phase_n    = STOP;
                bit_done_n = 1'b1;
            end
            STOP: if (tick_en) begin
                bit_done_n   = 1'b1;
                stop_cnt_n   = stop2 && !stop_cnt;
                phase_n      = (stop2 && !stop_cnt) ? STOP : IDLE;
                frame_done_n = !(stop2 && !stop_cnt);
            end
            default: phase_n = IDLE;
        endcase
        // Abort cancels a frame in flight and suppresses any pulse from the same tick.
        if (abort && phase != IDLE) begin
            phase_n      = IDLE;
            bit_index_n  = '0;
            stop_cnt_n   = 1'b0;
            bit_done_n   = 1'b0;
            data_done_n  = 1'b0;
            frame_done_n = 1'b0;
        end
        busy_n = phase_n != IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase      <= IDLE;
            busy       <= 1'b0;
            bit_index  <= '0;
            stop_cnt   <= 1'b0;
            data_bits  <= MAX_DB;
            parity_en  <= 1'b0;
            stop2      <= 1'b0;
            bit_done   <= 1'b0;
            data_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            phase      <= phase_n;
            busy       <= busy_n;
            bit_index  <= bit_index_n;
            stop_cnt   <= stop_cnt_n;
            data_bits  <= data_bits_n;
            parity_en  <= parity_en_n;
            stop2      <= stop2_n;
            bit_done   <= bit_done_n;
            data_done  <= data_done_n;
            frame_done <= frame_done_n;
        end
    end
endmodule

// File: tb/tb_uart_frame_counter.sv
// tb_uart_frame_counter: directed vector table plus hand sequences for reset and a 16-bit build.
module tb_uart_frame_counter;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, abort = 1'b0, tick_en = 1'b0;
    logic [3:0] cfg_data_bits = 4'd8;
    logic       cfg_parity_en = 1'b0, cfg_stop2 = 1'b0;
    logic       busy, bit_done, data_done, frame_done;
    logic [2:0] phase;
    logic [3:0] bit_index;

    logic       s16_start = 1'b0, s16_tick = 1'b0;
    logic [4:0] s16_cfg = 5'd16;
    logic       s16_busy, s16_bd, s16_dd, s16_fd;
    logic [2:0] s16_phase;
    logic [4:0] s16_idx;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    uart_frame_counter #(.MAX_DATA_BITS(8)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .tick_en(tick_en),
        .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en), .cfg_stop2(cfg_stop2),
        .busy(busy), .phase(phase), .bit_index(bit_index),
        .bit_done(bit_done), .data_done(data_done), .frame_done(frame_done)
    );

    uart_frame_counter #(.MAX_DATA_BITS(16)) dut16 (
        .clock(clock), .reset(reset), .start(s16_start), .abort(1'b0), .tick_en(s16_tick),
        .cfg_data_bits(s16_cfg), .cfg_parity_en(1'b0), .cfg_stop2(1'b0),
        .busy(s16_busy), .phase(s16_phase), .bit_index(s16_idx),
        .bit_done(s16_bd), .data_done(s16_dd), .frame_done(s16_fd)
    );

    typedef struct {
        logic       st, ab, tk;
        logic [3:0] db;
        logic       pe, s2;
        logic [2:0] ph;
        logic [3:0] idx;
        logic       bd, dd, fd;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, ab, tk, input logic [3:0] db, input logic pe, s2,
                                input logic [2:0] ph, input logic [3:0] idx, input logic bd, dd, fd);
        vec_t v;
        v.st = st; v.ab = ab; v.tk = tk; v.db = db; v.pe = pe; v.s2 = s2;
        v.ph = ph; v.idx = idx; v.bd = bd; v.dd = dd; v.fd = fd;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, ab, tk, input logic [3:0] db, input logic pe, s2);
        @(negedge clock);
        start = st; abort = ab; tick_en = tk;
        cfg_data_bits = db; cfg_parity_en = pe; cfg_stop2 = s2;
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [2:0] ph, input logic [3:0] idx,
                             input logic bd, dd, fd);
        chk({tag, " phase"}, 32'(phase), 32'(ph));
        chk({tag, " busy"}, 32'(busy), 32'(ph != 3'd0));
        chk({tag, " bit_index"}, 32'(bit_index), 32'(idx));
        chk({tag, " bit_done"}, 32'(bit_done), 32'(bd));
        chk({tag, " data_done"}, 32'(data_done), 32'(dd));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    task automatic cyc16(input logic st, tk);
        @(negedge clock);
        s16_start = st; s16_tick = tk;
        @(posedge clock);
        #1;
    endtask

    initial begin
        int fd_cnt, dd_cnt, fd_at, max_idx;
        // 8N1 frame
        add(1,0,0, 8,0,0, 1,0,0,0,0);
        add(0,0,1, 8,0,0, 2,0,1,0,0);
        for (int i = 1; i < 8; i++) add(0,0,1, 8,0,0, 2,4'(i),1,1,0);
        add(0,0,1, 8,0,0, 4,0,1,1,0);
        add(0,0,1, 8,0,0, 0,0,1,0,1);
        add(0,0,0, 8,0,0, 0,0,0,0,0);
        add(0,0,1, 8,0,0, 0,0,0,0,0);
        // 5 data, parity, 2 stop; start with tick; cfg scrambled mid-frame; start while busy
        add(1,0,1, 5,1,1, 1,0,0,0,0);
        add(0,0,1, 1,0,0, 2,0,1,0,0);
        add(1,0,0, 1,0,0, 2,0,0,0,0);
        for (int i = 1; i < 5; i++) add(0,0,1, 3,0,0, 2,4'(i),1,1,0);
        add(0,0,1, 0,0,0, 3,0,1,1,0);
        add(0,0,1, 0,0,0, 4,0,1,0,0);
        add(0,0,1, 0,0,0, 4,0,1,0,0);
        add(0,0,1, 0,0,0, 0,0,1,0,1);
        // clamp: cfg 0 then 15 back-to-back, second start in the frame_done cycle
        add(0,0,0, 0,0,0, 0,0,0,0,0);
        for (int f = 0; f < 2; f++) begin
            add(1,0,0, (f == 0) ? 4'd0 : 4'd15,0,0, 1,0,0,0,0);
            add(0,0,1, 2,1,1, 2,0,1,0,0);
            for (int i = 1; i < 8; i++) add(0,0,1, 2,1,1, 2,4'(i),1,1,0);
            add(0,0,1, 2,1,1, 4,0,1,1,0);
            add(0,0,1, 2,1,1, 0,0,1,0,1);
        end
        // abort in PARITY, then abort in IDLE
        add(1,0,0, 1,1,0, 1,0,0,0,0);
        add(0,0,1, 1,1,0, 2,0,1,0,0);
        add(0,0,1, 1,1,0, 3,0,1,1,0);
        add(0,1,1, 1,1,0, 0,0,0,0,0);
        add(0,0,1, 1,1,0, 0,0,0,0,0);
        add(0,1,1, 1,1,0, 0,0,0,0,0);

        #2;
        check_all("reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset busy16", 32'(s16_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            cyc(vecs[n].st, vecs[n].ab, vecs[n].tk, vecs[n].db, vecs[n].pe, vecs[n].s2);
            check_all($sformatf("v%0d", n), vecs[n].ph, vecs[n].idx, vecs[n].bd, vecs[n].dd, vecs[n].fd);
        end

        // asynchronous reset mid-DATA
        cyc(1,0,0, 8,0,0);
        for (int i = 0; i < 4; i++) cyc(0,0,1, 8,0,0);
        check_all("pre-reset", 3'd2, 4'd3, 1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0,0,1, 8,0,0);
            fd_cnt += int'(frame_done);
        end
        chk("post-reset frame_done", 32'(fd_cnt), 32'd0);
        check_all("post-reset", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        cyc(0,0,0, 8,0,0);

        // 16-bit build
        cyc16(1, 0);
        chk("w16 start phase", 32'(s16_phase), 32'd1);
        fd_cnt = 0; dd_cnt = 0; fd_at = 0; max_idx = 0;
        for (int t = 1; t <= 18; t++) begin
            cyc16(0, 1);
            dd_cnt += int'(s16_dd);
            if (s16_fd) begin fd_cnt++; fd_at = t; end
            if (int'(s16_idx) > max_idx) max_idx = int'(s16_idx);
            if (t == 16) begin
                chk("w16 t16 phase", 32'(s16_phase), 32'd2);
                chk("w16 t16 bit_index", 32'(s16_idx), 32'd15);
            end
            if (t == 17) chk("w16 t17 phase", 32'(s16_phase), 32'd4);
        end
        chk("w16 data_done count", 32'(dd_cnt), 32'd16);
        chk("w16 frame_done count", 32'(fd_cnt), 32'd1);
        chk("w16 frame_done tick", 32'(fd_at), 32'd18);
        chk("w16 max bit_index", 32'(max_idx), 32'd15);
        chk("w16 end busy", 32'(s16_busy), 32'd0);
        cyc16(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
